// File: rtl/note_sequencer_if.sv
// note_sequencer_if
// -----------------
// Bundles the control inputs and status outputs of the note sequencer.
//
// Signal contract, as seen from the sequencer (slave) side:
//   start_i, stop_i and loop_i are sampled on every rising clock edge; there
//   is no handshake and no backpressure, so a pulse must be at least one
//   cycle wide and is acted on in the cycle it is seen.
//   note_index_o, note_valid_o, note_strobe_o, playing_o and done_o are
//   registered and change only on the clock edge. note_valid_o qualifies
//   note_index_o for the tone generator: the ROM output is only to be
//   sounded while note_valid_o is high.
//   state_dbg_o mirrors the FSM state register (0 = IDLE, 1 = PLAY) for
//   checkers and debug.
//
// Modports:
//   master - the controller side (drives start/stop/loop, observes status)
//   slave  - the sequencer itself
interface note_sequencer_if;
  logic       start_i;
  logic       stop_i;
  logic       loop_i;
  logic [4:0] note_index_o;
  logic       note_valid_o;
  logic       note_strobe_o;
  logic       playing_o;
  logic       done_o;
  logic       state_dbg_o;

  modport master (
    output start_i,
    output stop_i,
    output loop_i,
    input  note_index_o,
    input  note_valid_o,
    input  note_strobe_o,
    input  playing_o,
    input  done_o,
    input  state_dbg_o
  );

  modport slave (
    input  start_i,
    input  stop_i,
    input  loop_i,
    output note_index_o,
    output note_valid_o,
    output note_strobe_o,
    output playing_o,
    output done_o,
    output state_dbg_o
  );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer
// --------------
// Steps the 5-bit note index through a song at a fixed tempo and tells the
// tone generator when to sound the looked-up divider. Each note slot lasts
// TICKS_PER_NOTE cycles; the last GAP_TICKS cycles of every slot are silent
// so repeated notes are articulated rather than merged.
//
// Ports:
//   clk_i  - system clock
//   rst_i  - synchronous, active-high reset
//   bus    - note_sequencer_if.slave:
//              start_i       begin / restart the song from slot 0
//              stop_i        abort playback, back to idle (wins over start_i)
//              loop_i        sampled in the last cycle of the last slot;
//                            high wraps to slot 0, low ends the song
//              note_index_o  current slot, drives the note ROM index
//              note_valid_o  high while the tone must sound
//              note_strobe_o one-cycle pulse in the first cycle of a slot
//              playing_o     high while in PLAY
//              done_o        one-cycle pulse when a non-looped song ends
//              state_dbg_o   FSM state (0 = IDLE, 1 = PLAY)
//
// Parameter legal ranges:
//   TICKS_PER_NOTE : 2 .. 2^TICK_BW-1
//   GAP_TICKS      : 0 .. TICKS_PER_NOTE-1
//   NUM_NOTES      : 1 .. 32
module note_sequencer #(
  parameter int TICK_BW        = 24,
  parameter int TICKS_PER_NOTE = 1500000,
  parameter int GAP_TICKS      = 150000,
  parameter int NUM_NOTES      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  note_sequencer_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // Last tick of a slot; the counter never goes beyond this value.
  localparam logic [TICK_BW-1:0] TICK_LAST   = TICK_BW'(TICKS_PER_NOTE - 1);
  // Ticks 0 .. SOUND_TICKS-1 of a slot sound, the rest is the gap.
  localparam logic [TICK_BW-1:0] SOUND_TICKS = TICK_BW'(TICKS_PER_NOTE - GAP_TICKS);
  // Wrap point of the index. Explicit compare, so short songs wrap early and
  // a 32-note song wraps at the same place natural overflow would.
  localparam logic [4:0]         INDEX_LAST  = 5'(NUM_NOTES - 1);

  state_t             state_q, state_d;
  logic [TICK_BW-1:0] tick_q,  tick_d;
  logic [4:0]         index_q, index_d;
  logic               valid_q, valid_d;
  logic               strobe_q, strobe_d;
  logic               done_q,  done_d;

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      index_q  <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      index_q  <= index_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state / next outputs.
  // Per-cycle priority: stop_i > start_i > tempo advance (reset is handled
  // in the register process and beats everything).
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    index_d  = index_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        tick_d  = '0;
        index_d = '0;
        // stop_i in IDLE has no effect of its own, but it still masks a
        // simultaneous start_i.
        if (!bus.stop_i && bus.start_i) begin
          state_d  = PLAY;
          strobe_d = 1'b1;
        end
      end

      PLAY: begin
        if (bus.stop_i) begin
          state_d = IDLE;
          tick_d  = '0;
          index_d = '0;
        end else if (bus.start_i) begin
          // Restart takes precedence over the tempo, so a restart on the
          // very last tick of the song never produces done_o.
          tick_d   = '0;
          index_d  = '0;
          strobe_d = 1'b1;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (index_q < INDEX_LAST) begin
            index_d  = index_q + 5'd1;
            strobe_d = 1'b1;
          end else if (bus.loop_i) begin
            index_d  = '0;
            strobe_d = 1'b1;
          end else begin
            state_d = IDLE;
            index_d = '0;
            done_d  = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tick_d  = '0;
        index_d = '0;
      end
    endcase

    // Valid is derived from where the slot will be next cycle, so it is
    // registered alongside the index it qualifies.
    valid_d = (state_d == PLAY) && (tick_d < SOUND_TICKS);
  end

  // ---------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------
  assign bus.note_index_o  = index_q;
  assign bus.note_valid_o  = valid_q;
  assign bus.note_strobe_o = strobe_q;
  assign bus.playing_o     = (state_q == PLAY);
  assign bus.done_o        = done_q;
  assign bus.state_dbg_o   = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
// -----------------
// Two sequencer instances:
//   A: TICKS_PER_NOTE=4, GAP_TICKS=1, NUM_NOTES=32
//   B: TICKS_PER_NOTE=4, GAP_TICKS=0, NUM_NOTES=3
// Both are compared every cycle against a position-based reference model
// (cycles elapsed since the song started), after directed scenarios and a
// randomized control phase.
module tb_note_sequencer;

  localparam int TPN_A = 4;
  localparam int GAP_A = 1;
  localparam int NN_A  = 32;
  localparam int TPN_B = 4;
  localparam int GAP_B = 0;
  localparam int NN_B  = 3;

  // -------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  note_sequencer_if if_a ();
  note_sequencer_if if_b ();

  note_sequencer #(
    .TICK_BW(24), .TICKS_PER_NOTE(TPN_A), .GAP_TICKS(GAP_A), .NUM_NOTES(NN_A)
  ) dut_a (
    .clk_i(clk),
    .rst_i(rst_a),
    .bus  (if_a.slave)
  );

  note_sequencer #(
    .TICK_BW(24), .TICKS_PER_NOTE(TPN_B), .GAP_TICKS(GAP_B), .NUM_NOTES(NN_B)
  ) dut_b (
    .clk_i(clk),
    .rst_i(rst_b),
    .bus  (if_b.slave)
  );

  // -------------------------------------------------------------------
  // Scoreboard counters and checker
  // -------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------
  // Reference model: a song is just "playing" plus the number of cycles
  // since it (re)started. Slot = pos / TPN, position in slot = pos % TPN.
  // -------------------------------------------------------------------
  int m_tpn [2];
  int m_gap [2];
  int m_nn  [2];
  bit m_play[2];
  int m_pos [2];
  bit m_done[2];

  task automatic model_update(input int d, input bit r, input bit st,
                              input bit sp, input bit lp);
    m_done[d] = 1'b0;
    if (r || sp) begin
      m_play[d] = 1'b0;
      m_pos[d]  = 0;
    end else if (st) begin
      m_play[d] = 1'b1;
      m_pos[d]  = 0;
    end else if (m_play[d]) begin
      m_pos[d]++;
      if (m_pos[d] == m_nn[d] * m_tpn[d]) begin
        m_pos[d] = 0;
        if (!lp) begin
          m_play[d] = 1'b0;
          m_done[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_dut(input int d);
    int pos_in_slot;
    int e_idx;
    int e_valid;
    int e_strobe;
    pos_in_slot = m_pos[d] % m_tpn[d];
    e_idx    = m_play[d] ? (m_pos[d] / m_tpn[d]) : 0;
    e_valid  = (m_play[d] && pos_in_slot < (m_tpn[d] - m_gap[d])) ? 1 : 0;
    e_strobe = (m_play[d] && pos_in_slot == 0) ? 1 : 0;
    if (d == 0) begin
      check_eq("a_index",   int'(if_a.note_index_o),  e_idx);
      check_eq("a_valid",   int'(if_a.note_valid_o),  e_valid);
      check_eq("a_strobe",  int'(if_a.note_strobe_o), e_strobe);
      check_eq("a_playing", int'(if_a.playing_o),     int'(m_play[d]));
      check_eq("a_done",    int'(if_a.done_o),        int'(m_done[d]));
      check_eq("a_state",   int'(if_a.state_dbg_o),   int'(m_play[d]));
    end else begin
      check_eq("b_index",   int'(if_b.note_index_o),  e_idx);
      check_eq("b_valid",   int'(if_b.note_valid_o),  e_valid);
      check_eq("b_strobe",  int'(if_b.note_strobe_o), e_strobe);
      check_eq("b_playing", int'(if_b.playing_o),     int'(m_play[d]));
      check_eq("b_done",    int'(if_b.done_o),        int'(m_done[d]));
      check_eq("b_state",   int'(if_b.state_dbg_o),   int'(m_play[d]));
    end
  endtask

  // -------------------------------------------------------------------
  // Driver: inputs are set with blocking assignments between steps; a step
  // takes one rising edge, advances the model with the sampled inputs and
  // compares 1 time unit later.
  // -------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    model_update(0, rst_a, if_a.start_i, if_a.stop_i, if_a.loop_i);
    model_update(1, rst_b, if_b.start_i, if_b.stop_i, if_b.loop_i);
    #1;
    compare_dut(0);
    compare_dut(1);
  endtask

  task automatic clear_a();
    if_a.start_i = 1'b0;
    if_a.stop_i  = 1'b0;
    if_a.loop_i  = 1'b0;
  endtask

  task automatic clear_b();
    if_b.start_i = 1'b0;
    if_b.stop_i  = 1'b0;
    if_b.loop_i  = 1'b0;
  endtask

  // Pulse start_i on A for one edge (edge 0); outputs then show cycle 1.
  task automatic start_a();
    if_a.start_i = 1'b1;
    step();
    if_a.start_i = 1'b0;
  endtask

  task automatic start_b();
    if_b.start_i = 1'b1;
    step();
    if_b.start_i = 1'b0;
  endtask

  // -------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------
  initial begin
    m_tpn[0] = TPN_A; m_gap[0] = GAP_A; m_nn[0] = NN_A;
    m_tpn[1] = TPN_B; m_gap[1] = GAP_B; m_nn[1] = NN_B;
    for (int d = 0; d < 2; d++) begin
      m_play[d] = 1'b0;
      m_pos[d]  = 0;
      m_done[d] = 1'b0;
    end
    clear_a();
    clear_b();
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Reset state
    step();
    step();
    check_eq("rst_a_index",   int'(if_a.note_index_o), 0);
    check_eq("rst_a_playing", int'(if_a.playing_o),    0);
    check_eq("rst_b_valid",   int'(if_b.note_valid_o), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step();

    // Full song, no loop: index 31 in 125..128, done at 129.
    start_a();
    check_eq("song_c1_playing", int'(if_a.playing_o),     1);
    check_eq("song_c1_strobe",  int'(if_a.note_strobe_o), 1);
    check_eq("song_c1_valid",   int'(if_a.note_valid_o),  1);
    for (int c = 2; c <= 130; c++) begin
      step();
      if (c == 4)   check_eq("song_c4_gap",      int'(if_a.note_valid_o),  0);
      if (c == 5)   check_eq("song_c5_strobe",   int'(if_a.note_strobe_o), 1);
      if (c == 125) check_eq("song_c125_index",  int'(if_a.note_index_o),  31);
      if (c == 129) begin
        check_eq("song_c129_done",    int'(if_a.done_o),       1);
        check_eq("song_c129_playing", int'(if_a.playing_o),    0);
        check_eq("song_c129_index",   int'(if_a.note_index_o), 0);
      end
      if (c == 130) check_eq("song_c130_done", int'(if_a.done_o), 0);
    end

    // Looped song, loop dropped during the second pass: done at 257.
    if_a.loop_i = 1'b1;
    start_a();
    for (int c = 2; c <= 258; c++) begin
      if (c == 200) if_a.loop_i = 1'b0;
      step();
      if (c == 129) begin
        check_eq("loop_c129_index",   int'(if_a.note_index_o),  0);
        check_eq("loop_c129_strobe",  int'(if_a.note_strobe_o), 1);
        check_eq("loop_c129_playing", int'(if_a.playing_o),     1);
        check_eq("loop_c129_done",    int'(if_a.done_o),        0);
      end
      if (c == 257) check_eq("loop_c257_done", int'(if_a.done_o), 1);
    end
    clear_a();

    // stop at cycle 20, then start+stop together at cycle 30.
    start_a();
    for (int c = 2; c <= 35; c++) begin
      if_a.stop_i  = (c == 21) || (c == 31);
      if_a.start_i = (c == 31);
      step();
      if (c == 21) begin
        check_eq("stop_c21_playing", int'(if_a.playing_o),    0);
        check_eq("stop_c21_valid",   int'(if_a.note_valid_o), 0);
        check_eq("stop_c21_done",    int'(if_a.done_o),       0);
      end
      if (c == 31) check_eq("startstop_c31_playing", int'(if_a.playing_o), 0);
    end
    clear_a();

    // Retrigger at cycle 50 (index 12).
    start_a();
    for (int c = 2; c <= 60; c++) begin
      if_a.start_i = (c == 51);
      step();
      if (c == 50) check_eq("retrig_c50_index", int'(if_a.note_index_o), 12);
      if (c == 51) begin
        check_eq("retrig_c51_index",  int'(if_a.note_index_o),  0);
        check_eq("retrig_c51_strobe", int'(if_a.note_strobe_o), 1);
        check_eq("retrig_c51_valid",  int'(if_a.note_valid_o),  1);
      end
      if (c == 55) check_eq("retrig_c55_index", int'(if_a.note_index_o), 1);
    end
    clear_a();
    if_a.stop_i = 1'b1;
    step();
    if_a.stop_i = 1'b0;

    // B: no gap, 3 notes -> continuous tone for 12 cycles, done at 13.
    start_b();
    check_eq("nogap_c1_valid", int'(if_b.note_valid_o), 1);
    for (int c = 2; c <= 14; c++) begin
      step();
      if (c <= 12) check_eq("nogap_valid", int'(if_b.note_valid_o), 1);
      if (c == 13) check_eq("nogap_c13_done", int'(if_b.done_o), 1);
    end

    // B rerun with reset at cycle 6: everything back to 0, no done.
    start_b();
    for (int c = 2; c <= 16; c++) begin
      rst_b = (c == 7);
      step();
      if (c == 7) begin
        check_eq("rst_c7_playing", int'(if_b.playing_o),    0);
        check_eq("rst_c7_index",   int'(if_b.note_index_o), 0);
        check_eq("rst_c7_valid",   int'(if_b.note_valid_o), 0);
      end
      if (c == 13) check_eq("rst_c13_done", int'(if_b.done_o), 0);
    end
    rst_b = 1'b0;

    // Randomized control on both instances.
    for (int i = 0; i < 4000; i++) begin
      rst_a        = ($urandom_range(0, 499) == 0);
      if_a.start_i = ($urandom_range(0, 69) == 0);
      if_a.stop_i  = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 99) == 0) if_a.loop_i = ~if_a.loop_i;
      rst_b        = ($urandom_range(0, 499) == 0);
      if_b.start_i = ($urandom_range(0, 19) == 0);
      if_b.stop_i  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) if_b.loop_i = ~if_b.loop_i;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
